// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller: key codes, controller state, digit decode.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package keypad_pkg;

    localparam logic [3:0] KEY_A     = 4'd10; // backspace
    localparam logic [3:0] KEY_B     = 4'd11; // clear
    localparam logic [3:0] KEY_C     = 4'd12; // reserved, accepted but ignored
    localparam logic [3:0] KEY_D     = 4'd15; // enter
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } ctrl_state_e;

    // An unknown code compares as X, which an if() treats as false, so an X
    // code falls through to "ignored" rather than entering the buffer.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/keypad_release_debounce.sv
// Row synchroniser plus release-debounce counter for the keypad entry controller.
// Latency: row_sync_o = row_raw_i delayed 2 cycles; released_o is combinational from the counter.
// Backpressure: none; the counter only advances while the controller reports hold/release.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   row_raw_i       asynchronous keypad rows
//   in_hold_i       controller is in HOLD
//   in_release_i    controller is in RELEASE
//   row_sync_o      synchronised rows
//   s_row_o         OR of synchronised rows
//   released_o      this cycle completes the required run of low cycles
module keypad_release_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_raw_i,
    input  logic       in_hold_i,
    input  logic       in_release_i,
    output logic [3:0] row_sync_o,
    output logic       s_row_o,
    output logic       released_o
);

    localparam int             CW    = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  DEB_W = CW'(DEB_CYCLES);

    logic [3:0]    meta_q;
    logic [3:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= row_raw_i;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign row_sync_o = sync_q;
    assign s_row_o    = |sync_q;

    // The first low cycle is seen while still in HOLD and counts as 1, so
    // reaching DEB_CYCLES inside RELEASE means DEB_CYCLES consecutive lows.
    always_comb begin
        cnt_inc    = cnt_q + CW'(1);
        released_o = in_release_i && !s_row_o && (cnt_inc == DEB_W);
        cnt_d      = '0;
        if (in_hold_i && !s_row_o) begin
            cnt_d = CW'(1);
        end else if (in_release_i && !s_row_o && !released_o) begin
            cnt_d = cnt_inc;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad sequencing controller: one accept per press, BCD operand entry with edit keys, valid/ready hand-off.
// Latency: accepted key -> buffer/ndig/out_valid/key_evt/err updated 1 cycle later.
// Backpressure: out_valid holds out_data until out_ready; a second enter while pending is rejected with err.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   row_raw               asynchronous keypad rows
//   row_sync, s_row       synchronised rows and their OR, to the scanner
//   key_code, key_valid   scanner result
//   disp_digits, ndig     live entry buffer (nibble 0 = least significant) and digit count
//   out_data, out_valid   committed operand, out_ready accepts it
//   key_evt, err          one-cycle pulses: press accepted / operation rejected
module keypad_entry_ctrl #(
    parameter int NDIG       = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  row_raw,
    output logic [3:0]                  row_sync,
    output logic                        s_row,
    input  logic [3:0]                  key_code,
    input  logic                        key_valid,
    output logic [4*NDIG-1:0]           disp_digits,
    output logic [$clog2(NDIG+1)-1:0]   ndig,
    output logic [4*NDIG-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        key_evt,
    output logic                        err
);

    import keypad_pkg::*;

    localparam int             NW     = $clog2(NDIG + 1);
    localparam logic [NW-1:0]  NDIG_W = NW'(NDIG);

    ctrl_state_e      state_q, state_d;
    logic [4*NDIG-1:0] buf_q, buf_d;
    logic [NW-1:0]     ndig_q, ndig_d;
    logic [4*NDIG-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              evt_q, evt_d;
    logic              err_q, err_d;
    logic              released;

    keypad_release_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk          (clk),
        .rst          (rst),
        .row_raw_i    (row_raw),
        .in_hold_i    (state_q == ST_HOLD),
        .in_release_i (state_q == ST_RELEASE),
        .row_sync_o   (row_sync),
        .s_row_o      (s_row),
        .released_o   (released)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARMED;
            buf_q       <= '0;
            ndig_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            evt_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            ndig_q      <= ndig_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            evt_q       <= evt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ndig_d     = ndig_q;
        out_data_d = out_data_q;
        // Handshake completion is independent of keys; a same-cycle enter
        // still sees the old out_valid_q and is rejected.
        out_valid_d = out_valid_q && !out_ready;
        evt_d       = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_ARMED: begin
                if (key_valid) begin
                    state_d = ST_HOLD;
                    evt_d   = 1'b1;
                    case (key_code)
                        KEY_A: begin
                            if (ndig_q != '0) begin
                                buf_d  = buf_q >> 4;
                                ndig_d = ndig_q - NW'(1);
                            end
                        end
                        KEY_B: begin
                            buf_d  = '0;
                            ndig_d = '0;
                        end
                        KEY_C: begin
                        end
                        KEY_D: begin
                            if (ndig_q != '0 && !out_valid_q) begin
                                out_data_d  = buf_q;
                                out_valid_d = 1'b1;
                                buf_d       = '0;
                                ndig_d      = '0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            if (is_digit(key_code)) begin
                                if (ndig_q < NDIG_W) begin
                                    buf_d      = buf_q << 4;
                                    buf_d[3:0] = key_code;
                                    ndig_d     = ndig_q + NW'(1);
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                if (!s_row) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (s_row) begin
                    state_d = ST_HOLD;
                end else if (released) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    assign disp_digits = buf_q;
    assign ndig        = ndig_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign key_evt     = evt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: digit list / armed-flag model checked every cycle, plus directed literal checks.
module tb_keypad_entry_ctrl;

    localparam int NDIG = 4;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_raw;
    logic [3:0]  row_sync;
    logic        s_row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] disp_digits;
    logic [2:0]  ndig;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        key_evt;
    logic        err;

    keypad_entry_ctrl #(.NDIG(NDIG), .DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_raw     (row_raw),
        .row_sync    (row_sync),
        .s_row       (s_row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .disp_digits (disp_digits),
        .ndig        (ndig),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .key_evt     (key_evt),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int evt_seen = 0;
    int err_seen = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Operand kept as a list of digits (most significant first); the press
    // acceptor is just "armed" plus a count of consecutive idle cycles.
    int          q_dig[$];
    logic [15:0] m_out   = '0;
    bit          m_ov    = 0;
    bit          m_evt   = 0;
    bit          m_err   = 0;
    bit          m_armed = 1;
    int          m_run   = 0;
    logic [3:0]  m_r1    = '0;
    logic [3:0]  m_r2    = '0;

    function automatic logic [15:0] pack_digits();
        int v = 0;
        foreach (q_dig[i]) v = v * 16 + q_dig[i];
        return v[15:0];
    endfunction

    always @(posedge clk) begin : model
        bit s;
        bit ov_was;
        int kc;
        if (rst) begin
            q_dig.delete();
            m_out = '0; m_ov = 0; m_evt = 0; m_err = 0;
            m_armed = 1; m_run = 0; m_r1 = '0; m_r2 = '0;
            chk_en = 1;
        end else begin
            s = (m_r2 != 4'd0);
            m_r2 = m_r1;
            m_r1 = row_raw;
            m_evt = 0;
            m_err = 0;
            ov_was = m_ov;
            if (m_ov && out_ready) m_ov = 0;
            if (m_armed && key_valid) begin
                m_evt = 1;
                m_armed = 0;
                m_run = 0;
                if (!$isunknown(key_code)) begin
                    kc = int'(key_code);
                    if (kc <= 9) begin
                        if (q_dig.size() < NDIG) q_dig.push_back(kc);
                        else m_err = 1;
                    end else if (kc == 10) begin
                        if (q_dig.size() > 0) void'(q_dig.pop_back());
                    end else if (kc == 11) begin
                        q_dig.delete();
                    end else if (kc == 15) begin
                        if (q_dig.size() > 0 && !ov_was) begin
                            m_out = pack_digits();
                            m_ov = 1;
                            q_dig.delete();
                        end else begin
                            m_err = 1;
                        end
                    end
                end
            end else if (!m_armed) begin
                if (!s) m_run++;
                else m_run = 0;
                if (m_run == DEB) begin
                    m_armed = 1;
                    m_run = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("row_sync", row_sync, m_r2);
            check("s_row", s_row, (m_r2 != 4'd0));
            check("disp_digits", disp_digits, pack_digits());
            check("ndig", ndig, q_dig.size());
            check("out_data", out_data, m_out);
            check("out_valid", out_valid, m_ov);
            check("key_evt", key_evt, m_evt);
            check("err", err, m_err);
            if (key_evt === 1'b1) evt_seen++;
            if (err === 1'b1) err_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Row goes high, scanner reports after the synchroniser, key is held, then released cleanly.
    task automatic press(input logic [3:0] code, input bit rdy_at_capture = 0);
        row_raw = 4'b0010;
        cyc(3);
        key_code  = code;
        key_valid = 1'b1;
        if (rdy_at_capture) out_ready = 1'b1;
        cyc(1);
        key_valid = 1'b0;
        out_ready = 1'b0;
        cyc(10);
        row_raw = 4'b0000;
        cyc(DEB + 4);
    endtask

    int e0, r0;
    logic [3:0] xcode;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; row_raw = '0; key_code = '0; key_valid = 1'b0; out_ready = 1'b0;
        cyc(3);
        check("rst_disp", disp_digits, 16'h0000);
        check("rst_ndig", ndig, 0);
        check("rst_ov", out_valid, 0);
        rst = 1'b0;
        cyc(2);

        // 1,2,3
        e0 = evt_seen; r0 = err_seen;
        press(4'd1); press(4'd2); press(4'd3);
        check("d123_disp", disp_digits, 16'h0123);
        check("d123_ndig", ndig, 3);
        check("d123_evt", evt_seen - e0, 3);
        check("d123_err", err_seen - r0, 0);

        // edits
        r0 = err_seen;
        press(4'd11); press(4'd4); press(4'd5);
        check("d45_disp", disp_digits, 16'h0045);
        press(4'd10);
        check("bs_disp", disp_digits, 16'h0004);
        check("bs_ndig", ndig, 1);
        press(4'd11);
        check("clr_disp", disp_digits, 16'h0000);
        check("clr_ndig", ndig, 0);
        press(4'd15);
        check("empty_enter_err", err_seen - r0, 1);
        check("empty_enter_ov", out_valid, 0);

        // full buffer, commit, enter while pending, handshake
        r0 = err_seen;
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        check("full_disp", disp_digits, 16'h9876);
        check("full_ndig", ndig, 4);
        press(4'd5);
        check("overflow_err", err_seen - r0, 1);
        check("overflow_disp", disp_digits, 16'h9876);
        press(4'd15);
        check("commit_ov", out_valid, 1);
        check("commit_data", out_data, 16'h9876);
        check("commit_disp", disp_digits, 16'h0000);
        press(4'd1);
        check("pend_entry", disp_digits, 16'h0001);
        press(4'd15);
        check("pend_enter_err", err_seen - r0, 2);
        check("pend_data", out_data, 16'h9876);
        check("pend_disp", disp_digits, 16'h0001);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("hs_ov_low", out_valid, 0);
        press(4'd15);
        check("commit2_data", out_data, 16'h0001);
        check("commit2_ov", out_valid, 1);
        press(4'd3);
        press(4'd15, 1);
        check("race_err", err_seen - r0, 3);
        check("race_ov", out_valid, 0);
        check("race_disp", disp_digits, 16'h0003);
        press(4'd11);

        // bounce: row chatter and scanner reports during hold/release
        e0 = evt_seen;
        row_raw = 4'b0100;
        cyc(3);
        key_code = 4'd7; key_valid = 1'b1;
        cyc(1);
        key_valid = 1'b0;
        cyc(2);
        row_raw = 4'b0000; cyc(2);
        row_raw = 4'b0100; key_code = 4'd3; key_valid = 1'b1; cyc(3);
        row_raw = 4'b0000; cyc(2);
        key_valid = 1'b0;
        row_raw = 4'b0100; cyc(3);
        row_raw = 4'b0000; cyc(DEB + 4);
        check("bounce_evt", evt_seen - e0, 1);
        check("bounce_ndig", ndig, 1);
        check("bounce_disp", disp_digits, 16'h0007);

        // ignored codes
        e0 = evt_seen; r0 = err_seen;
        press(4'd12); press(4'd13); press(4'd14);
        check("ign_disp", disp_digits, 16'h0007);
        check("ign_ndig", ndig, 1);
        check("ign_ov", out_valid, 0);
        check("ign_err", err_seen - r0, 0);
        check("ign_evt", evt_seen - e0, 3);
        xcode = 4'bxxxx;
        press(xcode);
        check("x_free", {29'd0, $isunknown(disp_digits), $isunknown(ndig), $isunknown(out_valid)}, 0);
        press(4'd11);

        // reset while a key is held, then re-report of the same key
        press(4'd1);
        row_raw = 4'b1000;
        cyc(3);
        key_code = 4'd2; key_valid = 1'b1;
        cyc(1);
        key_valid = 1'b0;
        cyc(3);
        check("hold_ndig", ndig, 2);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_disp", disp_digits, 16'h0000);
        check("mid_rst_ndig", ndig, 0);
        check("mid_rst_sync", row_sync, 4'h0);
        check("mid_rst_evt", key_evt, 0);
        rst = 1'b0;
        e0 = evt_seen;
        cyc(3);
        key_valid = 1'b1;
        cyc(1);
        key_valid = 1'b0;
        cyc(2);
        check("rearm_disp", disp_digits, 16'h0002);
        check("rearm_ndig", ndig, 1);
        check("rearm_evt", evt_seen - e0, 1);
        row_raw = 4'b0000;
        cyc(DEB + 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequencing controller for the hex keypad scanner.
- Synchronises the raw keypad rows and drives the scanner's row and s_row inputs.
- Accepts exactly one scanner code per physical press, with release debounce.
- Assembles digit keys into an NDIG-digit BCD operand with edit keys (backspace, clear, enter), then hands the operand to downstream logic over a valid/ready handshake.

Parameters:
- NDIG, 4, number of BCD digits in the entry buffer (≥1).
- DEB_CYCLES, 16, consecutive no-row cycles required to declare key release (≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- row_raw  input  4  asynchronous keypad row lines.
- row_sync  output  4  row_raw after 2-FF synchroniser; drives scanner row.
- s_row  output  1  OR of row_sync; drives scanner s_row.
- key_code  input  4  scanner code output.
- key_valid  input  1  scanner valido.
- disp_digits  output  4*NDIG  live entry buffer; nibble 0 = least significant digit.
- ndig  output  $clog2(NDIG+1)  digits currently in buffer.
- out_data  output  4*NDIG  committed operand.
- out_valid  output  1  out_data valid; held until accepted.
- out_ready  input  1  downstream accepts out_data when out_valid & out_ready.
- key_evt  output  1  one-cycle pulse per accepted press.
- err  output  1  one-cycle pulse on rejected operation.

Behaviour:
- Reset (synchronous, rst=1 at posedge): all outputs and internal registers go to 0. State is ARMED. Debounce counter is 0.
- Synchroniser: row_sync = row_raw delayed 2 cycles. s_row is combinational OR of row_sync.
- State machine (ARMED, HOLD, RELEASE):
  - ARMED: if key_valid=1, capture key_code, process it this cycle (register updates visible next cycle), pulse key_evt, go to HOLD. key_valid=0 keeps ARMED.
  - HOLD: if s_row=0, go to RELEASE with cnt=1; else stay. key_valid is ignored.
  - RELEASE: if s_row=1, go back to HOLD and clear cnt. Else cnt++. When cnt reaches DEB_CYCLES, go to ARMED. key_valid is ignored.
- Key processing (ARMED capture only):
  - Code 0–9, ndig<NDIG: buffer shifts left one nibble, new digit enters nibble 0, ndig+1.
  - Code 0–9, ndig=NDIG: buffer unchanged; err pulse.
  - Code 10 (A, backspace): buffer shifts right one nibble, top nibble zeroed, ndig-1. If ndig=0, no-op with no err.
  - Code 11 (B, clear): buffer=0, ndig=0. No err.
  - Code 12 (C): ignored, key_evt still pulses.
  - Code 15 (D, enter): if ndig>0 and out_valid=0, then out_data<=buffer, out_valid<=1, buffer<=0, ndig<=0. If ndig=0 or out_valid=1, nothing changes and err pulses.
  - Codes 13, 14 or X/Z (*, #): ignored, no err. An X code must not corrupt state; treat it as "ignored" via a case default.
- Handshake:
  - out_valid falls the cycle after out_valid & out_ready.
  - out_data is stable while out_valid=1.
  - Digit entry continues while out_valid=1.
  - Enter and handshake completion in the same cycle: out_valid=1 at capture ⇒ err. The completion still clears out_valid.
- Latency: key_valid capture → disp_digits/ndig/out_valid update 1 cycle later. key_evt/err are asserted in the cycle following capture.
- Bounce: row chatter during HOLD/RELEASE never produces a second accept. Re-arming needs DEB_CYCLES clean low cycles.
- Reset mid-press: controller returns to ARMED. If the key is still held, the scanner re-reports it and it is accepted once.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants: KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=15, digit max 9;
  - ctrl state enum (ARMED, HOLD, RELEASE).
- One natural sub-module, keypad_release_debounce: the 2-FF synchroniser plus the release counter. It outputs row_sync, s_row and released. The entry/handshake logic stays in the top.

Test Plan:
- Reset, then press 1,2,3 (each held 10 cycles, released ≥DEB_CYCLES) → disp_digits=16'h0123, ndig=3, three key_evt pulses, err never asserted.
- Press 4,5 then A (backspace) → 16'h0004, ndig=1. Then B → 0, ndig=0. Then D → err pulse, out_valid stays 0.
- Enter 9,8,7,6, press 5 → err, buffer stays 16'h9876. Press D with out_ready=0 → out_valid=1, out_data=16'h9876, buffer 0. Press 1 then D → err, out_data unchanged. Raise out_ready one cycle → out_valid=0 next cycle.
- Bounce (DEB_CYCLES=4): hold key 7 with row_raw toggling low for 2 cycles twice → single key_evt, ndig=1. key_valid during HOLD/RELEASE → ignored.
- Codes 12, 13, 14 and 4'bxxxx on key_valid → buffer/ndig/out_valid unchanged, no err, no X on outputs.
- Assert rst during HOLD with ndig=2 → next cycle all outputs 0, state ARMED. The held key is re-accepted once after rst drops.
